alarma_secuenciador: RTL and testbench
======================================

# alarma_secuenciador

Controller for the sensor-alarm path. It latches the four sensor requests (corto, gas, humo, temp) and runs the siren and silence state machine with a silence timeout. It also rotates the display between active alarms and scans the 4-digit 7-segment display. It sits between the receiver block that decodes `dato` into `sensores`/silence/reset and the board's `SSD` and `leds` pins.

## Interface
- `DWELL_CYC`, 50_000_000: cycles each latched alarm stays on the display before rotation.
- `SIL_CYC`, 250_000_000: silence duration in cycles before the siren re-arms.
- `SCAN_CYC`, 50_000: cycles per digit in the display scan.
- `CLK_puar`  in  1  system clock; all state changes on its rising edge.
- `restart`  in  1  asynchronous, active-low reset.
- `sensores`  in  4  level requests, sampled every cycle: [3]=corto, [2]=gas, [1]=humo, [0]=temp. Bit i is sensor number i+1.
- `silenciar`  in  1  one-cycle silence pulse.
- `reinicio`  in  1  one-cycle clear request for latched alarms.
- `SSD`  out  11  [10:7] anodes (digit3..digit0), active-low; [6:0] segments g..a, active-low.
- `leds`  out  3  [2]=siren, [1]=silenced, [0]=system OK (no latched alarm).
- `activa`  out  4  latched alarm vector.

## Operation
- **Latch**
  - At each edge: `activa[i] <= sensores[i] | (activa[i] & ~(reinicio & ~sensores[i]))`.
  - `reinicio` clears only bits whose sensor is currently low.
  - `new_alarm` means some bit goes 0→1 at this edge.
- **State machine** (registered, 2-bit):
  - IDLE → ALARM when `activa` ≠ 0.
  - ALARM → SILENCED on `silenciar`. Silence timer is loaded to 0.
  - SILENCED → ALARM when the timer reaches SIL_CYC-1, or on `new_alarm`.
  - SILENCED: `silenciar` again restarts the timer at 0.
  - ALARM or SILENCED → IDLE when `activa` = 0.
  - `silenciar` in IDLE is ignored.
  - Priority at one edge: `activa`=0 beats `new_alarm`, which beats `silenciar`, which beats timeout.
- **leds** (Moore outputs):
  - IDLE = 3'b001
  - ALARM = 3'b100
  - SILENCED = 3'b010
- **Rotation pointer** `ptr` (2 bits, sensor index):
  - Dwell counter runs while `activa` ≠ 0.
  - At DWELL_CYC-1: `ptr` moves to the next set bit searching ptr+1, ptr+2, … cyclically mod 4, and the counter resets. If `ptr`'s own bit is the only one set, `ptr` is unchanged.
  - If `activa[ptr]` = 0 while `activa` ≠ 0, `ptr` moves the same way at the next edge and the dwell counter resets.
  - In IDLE: `ptr` = 0, dwell counter = 0.
- **Digit content**
  - digit3: 'A' in ALARM or SILENCED, '-' in IDLE.
  - digit2: blank.
  - digit1: popcount(`activa`), shown as 0–4.
  - digit0: ptr+1 when `activa` ≠ 0, blank in IDLE.
- **Segment codes** (g..a, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 'A' = 0001000, '-' = 0111111, blank = 1111111
- **Scan**
  - Digit counter cycles 0,1,2,3,0, advancing every SCAN_CYC cycles.
  - Anode for digit d is low (e.g. digit0 → [10:7] = 4'b1110), with that digit's segments.
- **Counter widths**
  - Each counter is $clog2 of its parameter.
  - Counters compare with equality to PARAM-1, wrap to 0, and never overflow.

## Timing
- **Reset** (`restart` low, async): `activa` = 0, state IDLE, all counters and `ptr` = 0, `SSD` = 11'h7FF, `leds` = 3'b001.
- After reset release: first scan output appears on the first edge (digit0 anode low, blank).
- **Latency**
  - Sensor high sampled at edge N → `activa` set after edge N.
  - State/`leds` change after edge N+1.
  - `SSD` content is registered and reflects state one edge after the state change.
- **Silence**
  - `silenciar` at edge N → `leds` = 010 after edge N.
  - Re-arm occurs exactly SIL_CYC edges later if nothing else happens.
- **Reset mid-operation** aborts immediately; no alarm state survives.

## Test plan
Parameters: DWELL_CYC=8, SIL_CYC=20, SCAN_CYC=2.
- **Latch and siren:** reset, then `sensores`=4'b0100 for 1 cycle → `activa`=0100 one edge later, `leds`=100 one edge after that. `activa` stays 0100 after the sensor drops.
- **Silence timeout:** in ALARM, pulse `silenciar` → `leds`=010. Exactly 20 edges later → `leds`=100. A second pulse at edge 10 delays re-arm to edge 30.
- **New alarm overrides silence:** in SILENCED with `activa`=0100, raise `sensores[0]` → `activa`=0101 and `leds`=100 on the following edge. Simultaneous `silenciar` + new bit → `leds`=100.
- **Rotation:** `activa`=1001 → digit0 alternates '1'(1111001) and '4'(0011001) every 8 cycles. digit1 shows '2'(0100100), digit3 shows 'A'.
- **Clear rules:** `reinicio` with `sensores`=1000 and `activa`=1001 → `activa`=1000. Then `reinicio` with `sensores`=0 → `activa`=0, `leds`=001, digit3 '-', digit0 blank.
- **Async reset mid-silence:** assert `restart`=0 in SILENCED → `SSD`=11'h7FF and `leds`=001 with no clock edge. After release the anodes scan 1110, 1101, 1011, 0111 every 2 cycles.

Source files
------------

// File: rtl/alarma_secuenciador.sv
// Sensor-alarm controller: latches the four sensor requests, runs the siren/silence
// state machine with a silence timeout, rotates the display between active alarms
// and scans a 4-digit active-low 7-segment display.
module alarma_secuenciador #(
    parameter int unsigned DWELL_CYC = 50_000_000,
    parameter int unsigned SIL_CYC   = 250_000_000,
    parameter int unsigned SCAN_CYC  = 50_000
) (
    input  logic        CLK_puar,
    input  logic        restart,
    input  logic [3:0]  sensores,
    input  logic        silenciar,
    input  logic        reinicio,
    output logic [10:0] SSD,
    output logic [2:0]  leds,
    output logic [3:0]  activa
);

    localparam int unsigned DwellW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam int unsigned SilW   = (SIL_CYC > 1) ? $clog2(SIL_CYC) : 1;
    localparam int unsigned ScanW  = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;

    localparam logic [DwellW-1:0] DwellLast = DwellW'(DWELL_CYC - 1);
    localparam logic [SilW-1:0]   SilLast   = SilW'(SIL_CYC - 1);
    localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_CYC - 1);

    // Segment patterns, g..a, active-low
    localparam logic [6:0] SegA     = 7'b0001000;
    localparam logic [6:0] SegDash  = 7'b0111111;
    localparam logic [6:0] SegBlank = 7'b1111111;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StAlarm    = 2'd1,
        StSilenced = 2'd2
    } state_e;

    logic [3:0]        activa_q, activa_d;
    logic              new_alarm;
    state_e            state_q;
    logic [2:0]        leds_q;
    logic [SilW-1:0]   sil_q;
    logic [1:0]        ptr_q, ptr_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [ScanW-1:0]  scan_q, scan_d;
    logic [1:0]        dig_q, dig_d;
    logic [10:0]       ssd_q, ssd_d;

    // Next set bit after p, searching p+1, p+2, p+3 cyclically; p itself if none
    function automatic logic [1:0] next_set(input logic [1:0] p, input logic [3:0] v);
        logic [1:0] r;
        logic [1:0] idx;
        r = p;
        for (int k = 3; k >= 1; k--) begin
            idx = p + 2'(k);
            if (v[idx]) r = idx;
        end
        return r;
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [6:0] seg_num(input logic [2:0] n);
        logic [6:0] s;
        case (n)
            3'd0:    s = 7'b1000000;
            3'd1:    s = 7'b1111001;
            3'd2:    s = 7'b0100100;
            3'd3:    s = 7'b0110000;
            3'd4:    s = 7'b0011001;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    // Latch: sensors set bits; reinicio clears only bits whose sensor is low
    always_comb begin
        activa_d  = sensores | (activa_q & ~({4{reinicio}} & ~sensores));
        new_alarm = |(activa_d & ~activa_q);
    end

    // Latched alarm register
    always_ff @(posedge CLK_puar or negedge restart) begin
        if (!restart) begin
            activa_q <= '0;
        end else begin
            activa_q <= activa_d;
        end
    end

    // Siren/silence FSM with registered leds and silence timer
    always_ff @(posedge CLK_puar or negedge restart) begin
        if (!restart) begin
            state_q <= StIdle;
            leds_q  <= 3'b001;
            sil_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    sil_q <= '0;
                    if (activa_q != 4'b0000) begin
                        state_q <= StAlarm;
                        leds_q  <= 3'b100;
                    end
                end
                StAlarm: begin
                    sil_q <= '0;
                    if (activa_q == 4'b0000) begin
                        state_q <= StIdle;
                        leds_q  <= 3'b001;
                    end else if (silenciar && !new_alarm) begin
                        state_q <= StSilenced;
                        leds_q  <= 3'b010;
                    end
                end
                StSilenced: begin
                    if (activa_q == 4'b0000) begin
                        state_q <= StIdle;
                        leds_q  <= 3'b001;
                        sil_q   <= '0;
                    end else if (new_alarm) begin
                        state_q <= StAlarm;
                        leds_q  <= 3'b100;
                        sil_q   <= '0;
                    end else if (silenciar) begin
                        sil_q <= '0;
                    end else if (sil_q == SilLast) begin
                        state_q <= StAlarm;
                        leds_q  <= 3'b100;
                        sil_q   <= '0;
                    end else begin
                        sil_q <= sil_q + SilW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    leds_q  <= 3'b001;
                    sil_q   <= '0;
                end
            endcase
        end
    end

    // Rotation pointer: hop on dwell expiry or when the pointed bit is cleared
    always_comb begin
        ptr_d   = ptr_q;
        dwell_d = dwell_q;
        if (activa_q == 4'b0000) begin
            ptr_d   = 2'd0;
            dwell_d = '0;
        end else if (!activa_q[ptr_q] || (dwell_q == DwellLast)) begin
            ptr_d   = next_set(ptr_q, activa_q);
            dwell_d = '0;
        end else begin
            dwell_d = dwell_q + DwellW'(1);
        end
    end

    // Display scan: digit index advances every SCAN_CYC cycles
    always_comb begin
        dig_d  = dig_q;
        scan_d = scan_q + ScanW'(1);
        if (scan_q == ScanLast) begin
            scan_d = '0;
            dig_d  = dig_q + 2'd1;
        end
    end

    // Digit content for the currently scanned digit
    always_comb begin
        logic [6:0] seg;
        seg = SegBlank;
        case (dig_q)
            2'd3: seg = (state_q == StIdle) ? SegDash : SegA;
            2'd2: seg = SegBlank;
            2'd1: seg = seg_num(popcount4(activa_q));
            default: seg = (activa_q == 4'b0000) ? SegBlank : seg_num({1'b0, ptr_q} + 3'd1);
        endcase
        ssd_d = {~(4'b0001 << dig_q), seg};
    end

    // Rotation, scan and display registers
    always_ff @(posedge CLK_puar or negedge restart) begin
        if (!restart) begin
            ptr_q   <= 2'd0;
            dwell_q <= '0;
            scan_q  <= '0;
            dig_q   <= 2'd0;
            ssd_q   <= 11'h7FF;
        end else begin
            ptr_q   <= ptr_d;
            dwell_q <= dwell_d;
            scan_q  <= scan_d;
            dig_q   <= dig_d;
            ssd_q   <= ssd_d;
        end
    end

    assign SSD    = ssd_q;
    assign leds   = leds_q;
    assign activa = activa_q;

endmodule

// File: tb/tb_alarma_secuenciador.sv
// Directed self-checking bench for alarma_secuenciador (DWELL=8, SIL=20, SCAN=2).
module tb_alarma_secuenciador;

    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] S1    = 7'b1111001;
    localparam logic [6:0] S2    = 7'b0100100;
    localparam logic [6:0] S4    = 7'b0011001;
    localparam logic [6:0] SA    = 7'b0001000;
    localparam logic [6:0] SDASH = 7'b0111111;
    localparam logic [6:0] SBL   = 7'b1111111;

    logic        clk;
    logic        restart;
    logic [3:0]  sensores;
    logic        silenciar;
    logic        reinicio;
    logic [10:0] ssd;
    logic [2:0]  leds;
    logic [3:0]  activa;

    int n_checks;
    int n_fail;

    alarma_secuenciador #(
        .DWELL_CYC(8),
        .SIL_CYC  (20),
        .SCAN_CYC (2)
    ) dut (
        .CLK_puar (clk),
        .restart  (restart),
        .sensores (sensores),
        .silenciar(silenciar),
        .reinicio (reinicio),
        .SSD      (ssd),
        .leds     (leds),
        .activa   (activa)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Wait for the start of a fresh scan window of anode pattern an, return its segments
    task automatic wait_digit(input logic [3:0] an, output logic [6:0] seg);
        int found;
        found = 0;
        for (int i = 0; i < 16 && ssd[10:7] == an; i++) tick();
        for (int i = 0; i < 16; i++) begin
            if (ssd[10:7] == an) begin
                found = 1;
                break;
            end
            tick();
        end
        check_eq("win_found", found, 1);
        seg = ssd[6:0];
    endtask

    logic [6:0] seg_v1, seg_v2, seg_v3, seg_t;
    logic [3:0] an_tab [8];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        restart   = 1'b0;
        sensores  = 4'b0000;
        silenciar = 1'b0;
        reinicio  = 1'b0;
        an_tab    = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011, 4'b1011, 4'b0111, 4'b0111};

        // Reset values
        #12;
        check_eq("rst_ssd", ssd, 11'h7FF);
        check_eq("rst_leds", leds, 3'b001);
        check_eq("rst_activa", activa, 4'b0000);
        @(posedge clk);
        #1;
        restart = 1'b1;
        tick();
        check_eq("first_scan", ssd, {4'b1110, SBL});

        // Latch and siren
        sensores = 4'b0100;
        tick();
        check_eq("latch_activa", activa, 4'b0100);
        check_eq("latch_leds_idle", leds, 3'b001);
        sensores = 4'b0000;
        tick();
        check_eq("siren_on", leds, 3'b100);
        ticks(3);
        check_eq("latch_hold", activa, 4'b0100);

        // Silence timeout: re-arm exactly 20 edges after the pulse
        silenciar = 1'b1;
        tick();
        silenciar = 1'b0;
        check_eq("sil_leds", leds, 3'b010);
        ticks(19);
        check_eq("sil_edge19", leds, 3'b010);
        tick();
        check_eq("sil_rearm20", leds, 3'b100);

        // Second pulse at edge 10 pushes re-arm to edge 30
        silenciar = 1'b1;
        tick();
        silenciar = 1'b0;
        check_eq("sil2_leds", leds, 3'b010);
        ticks(9);
        silenciar = 1'b1;
        tick();
        silenciar = 1'b0;
        check_eq("sil2_edge10", leds, 3'b010);
        ticks(19);
        check_eq("sil2_edge29", leds, 3'b010);
        tick();
        check_eq("sil2_rearm30", leds, 3'b100);

        // New alarm overrides silence
        silenciar = 1'b1;
        tick();
        silenciar = 1'b0;
        tick();
        check_eq("new_pre", leds, 3'b010);
        sensores = 4'b0001;
        tick();
        sensores = 4'b0000;
        check_eq("new_activa", activa, 4'b0101);
        check_eq("new_leds", leds, 3'b100);
        silenciar = 1'b1;
        tick();
        check_eq("new2_pre", leds, 3'b010);
        sensores = 4'b1000;
        tick();
        silenciar = 1'b0;
        sensores  = 4'b0000;
        check_eq("new_sil_leds", leds, 3'b100);
        check_eq("new_sil_activa", activa, 4'b1101);

        // Clear bit 2 while holding bits 3 and 0 high
        sensores = 4'b1001;
        reinicio = 1'b1;
        tick();
        sensores = 4'b0000;
        reinicio = 1'b0;
        check_eq("clr_partial", activa, 4'b1001);
        check_eq("clr_leds", leds, 3'b100);

        // Rotation between sensors 1 and 4
        ticks(4);
        wait_digit(4'b1101, seg_t);
        check_eq("rot_digit1", seg_t, S2);
        wait_digit(4'b0111, seg_t);
        check_eq("rot_digit3", seg_t, SA);
        wait_digit(4'b1110, seg_v1);
        wait_digit(4'b1110, seg_v2);
        wait_digit(4'b1110, seg_v3);
        check_eq("rot_first", (seg_v1 == S1) || (seg_v1 == S4), 1);
        check_eq("rot_alt1", seg_v2, (seg_v1 == S1) ? S4 : S1);
        check_eq("rot_alt2", seg_v3, seg_v1);

        // Clear rules
        sensores = 4'b1000;
        reinicio = 1'b1;
        tick();
        check_eq("clr_keep_high", activa, 4'b1000);
        sensores = 4'b0000;
        tick();
        reinicio = 1'b0;
        check_eq("clr_all", activa, 4'b0000);
        check_eq("clr_leds_lag", leds, 3'b100);
        tick();
        check_eq("clr_idle", leds, 3'b001);
        wait_digit(4'b0111, seg_t);
        check_eq("idle_digit3", seg_t, SDASH);
        wait_digit(4'b1110, seg_t);
        check_eq("idle_digit0", seg_t, SBL);
        wait_digit(4'b1101, seg_t);
        check_eq("idle_digit1", seg_t, S0);

        // Async reset mid-silence
        sensores = 4'b0010;
        tick();
        sensores = 4'b0000;
        tick();
        check_eq("ar_alarm", leds, 3'b100);
        silenciar = 1'b1;
        tick();
        silenciar = 1'b0;
        check_eq("ar_silenced", leds, 3'b010);
        #2;
        restart = 1'b0;
        #1;
        check_eq("ar_ssd", ssd, 11'h7FF);
        check_eq("ar_leds", leds, 3'b001);
        check_eq("ar_activa", activa, 4'b0000);
        @(posedge clk);
        #1;
        check_eq("ar_hold_ssd", ssd, 11'h7FF);
        restart = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("ar_scan_anode", ssd[10:7], an_tab[i]);
        end
        check_eq("ar_post_leds", leds, 3'b001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
